// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes, immediate formats
// and the ID/EX slot layout, plus immediate and ALU-op helpers.
package decode_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_PASSB = 5'd10,
    ALU_AUIPC = 5'd11,
    ALU_LINK  = 5'd12
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    alu_op_e           alu_op;
    logic [2:0]        funct3;
    logic              reg_we;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              is_jal;
    logic              is_jalr;
    logic              alu_src_imm;
    logic              illegal;
  } id_ex_t;

  function automatic logic [XLEN-1:0] gen_imm(input logic [XLEN-1:0] ir, input imm_fmt_e fmt);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   imm = {ir[31:12], 12'b0};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Bit 30 selects SUB only for register-register; for immediates it only picks SRA.
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic b30, input logic is_imm);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = (b30 && !is_imm) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = b30 ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one write port; x0 is hard-wired to zero.
module decode_regfile
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0]   mem_reg [NREGS];
  logic [REG_AW-1:0] ra      [2];
  logic [XLEN-1:0]   rdata   [2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) mem_reg[i] <= '0;
    end else if (we && wa != '0) begin
      mem_reg[wa] <= wd;
    end
  end

  assign ra[0] = ra1;
  assign ra[1] = ra2;

  // A nonzero read index matching the write index implies wa != 0, so x0 stays 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rdata[gi] = (ra[gi] == '0)          ? '0 :
                       (we && wa == ra[gi])    ? wd :
                                                 mem_reg[ra[gi]];
  end

  assign rd1 = rdata[0];
  assign rd2 = rdata[1];

endmodule

// File: rtl/decode.sv
// RV32I decode stage: instruction decode, load-use hazard detection and the
// ID/EX pipeline register, with register file reads through decode_regfile.
module decode
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   ir,
  input  logic [XLEN-1:0]   npc,
  input  logic              branch_sig,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [4:0]        ex_alu_op,
  output logic [2:0]        ex_funct3,
  output logic              ex_reg_we,
  output logic              ex_is_load,
  output logic              ex_is_store,
  output logic              ex_is_branch,
  output logic              ex_is_jal,
  output logic              ex_is_jalr,
  output logic              ex_alu_src_imm,
  output logic              ex_illegal
);

  id_ex_t          ex_reg, ex_next;
  imm_fmt_e        fmt;
  logic            rs1_used, rs2_used, hazard;
  logic [XLEN-1:0] rs1_val, rs2_val;

  decode_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (ir[19:15]),
    .ra2   (ir[24:20]),
    .rd1   (rs1_val),
    .rd2   (rs2_val),
    .we    (wb_we),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  always_comb begin
    ex_next         = '0;
    fmt             = IMM_NONE;
    rs1_used        = 1'b1;
    rs2_used        = 1'b0;
    ex_next.valid   = 1'b1;
    ex_next.pc      = npc;
    ex_next.rs1     = ir[19:15];
    ex_next.rs2     = ir[24:20];
    ex_next.rd      = ir[11:7];
    ex_next.funct3  = ir[14:12];
    ex_next.rs1_val = rs1_val;
    ex_next.rs2_val = rs2_val;
    ex_next.alu_op  = ALU_ADD;
    case (ir[6:0])
      OPC_LUI: begin
        ex_next.reg_we = 1'b1; ex_next.alu_src_imm = 1'b1;
        ex_next.alu_op = ALU_PASSB; fmt = IMM_U; rs1_used = 1'b0;
      end
      OPC_AUIPC: begin
        ex_next.reg_we = 1'b1; ex_next.alu_src_imm = 1'b1;
        ex_next.alu_op = ALU_AUIPC; fmt = IMM_U; rs1_used = 1'b0;
      end
      OPC_JAL: begin
        ex_next.reg_we = 1'b1; ex_next.is_jal = 1'b1;
        ex_next.alu_op = ALU_LINK; fmt = IMM_J; rs1_used = 1'b0;
      end
      OPC_JALR: begin
        ex_next.reg_we = 1'b1; ex_next.is_jalr = 1'b1; ex_next.alu_src_imm = 1'b1;
        ex_next.alu_op = ALU_LINK; fmt = IMM_I;
      end
      OPC_BRANCH: begin
        ex_next.is_branch = 1'b1; fmt = IMM_B; rs2_used = 1'b1;
        case (ir[14:13])
          2'b10:   ex_next.alu_op = ALU_SLT;
          2'b11:   ex_next.alu_op = ALU_SLTU;
          default: ex_next.alu_op = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        ex_next.reg_we = 1'b1; ex_next.is_load = 1'b1; ex_next.alu_src_imm = 1'b1;
        fmt = IMM_I;
      end
      OPC_STORE: begin
        ex_next.is_store = 1'b1; ex_next.alu_src_imm = 1'b1;
        fmt = IMM_S; rs2_used = 1'b1;
      end
      OPC_OPIMM: begin
        ex_next.reg_we = 1'b1; ex_next.alu_src_imm = 1'b1; fmt = IMM_I;
        ex_next.alu_op = alu_from_funct(ir[14:12], ir[30], 1'b1);
      end
      OPC_OP: begin
        ex_next.reg_we = 1'b1; rs2_used = 1'b1;
        ex_next.alu_op = alu_from_funct(ir[14:12], ir[30], 1'b0);
      end
      default: ex_next.illegal = 1'b1;
    endcase
    ex_next.imm = gen_imm(ir, fmt);
  end

  // Load in ID/EX whose destination is a source the current instruction reads.
  assign hazard = ex_reg.valid && ex_reg.is_load && (ex_reg.rd != '0) &&
                  ((rs1_used && ex_reg.rd == ex_next.rs1) ||
                   (rs2_used && ex_reg.rd == ex_next.rs2));
  assign stall  = hazard && !branch_sig;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_reg <= '0;
    end else if (branch_sig || hazard) begin
      ex_reg <= '0;
    end else begin
      ex_reg <= ex_next;
    end
  end

  assign ex_valid       = ex_reg.valid;
  assign ex_pc          = ex_reg.pc;
  assign ex_rs1_val     = ex_reg.rs1_val;
  assign ex_rs2_val     = ex_reg.rs2_val;
  assign ex_imm         = ex_reg.imm;
  assign ex_rs1         = ex_reg.rs1;
  assign ex_rs2         = ex_reg.rs2;
  assign ex_rd          = ex_reg.rd;
  assign ex_alu_op      = ex_reg.alu_op;
  assign ex_funct3      = ex_reg.funct3;
  assign ex_reg_we      = ex_reg.reg_we;
  assign ex_is_load     = ex_reg.is_load;
  assign ex_is_store    = ex_reg.is_store;
  assign ex_is_branch   = ex_reg.is_branch;
  assign ex_is_jal      = ex_reg.is_jal;
  assign ex_is_jalr     = ex_reg.is_jalr;
  assign ex_alu_src_imm = ex_reg.alu_src_imm;
  assign ex_illegal     = ex_reg.illegal;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: expected ID/EX contents are queued as each
// instruction is driven and compared once the clock edge has captured it.
module tb_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir = '0, npc = '0;
  logic        branch_sig = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_alu_op;
  logic [2:0]  ex_funct3;
  logic        ex_reg_we, ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic        ex_alu_src_imm, ex_illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1_val, rs2_val, imm;
    logic [4:0]  rd;
    logic        reg_we, is_load, is_branch, illegal;
    logic        data_chk;
    logic        rs2_chk;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
  localparam logic [31:0] ADDI_X6_X5 = 32'h0002_8313;
  localparam logic [31:0] ADDI_X7_X0 = 32'h0000_0393;
  localparam logic [31:0] LW_X2_X1   = 32'h0000_A103;
  localparam logic [31:0] ADD_X3_X2  = 32'h0021_01B3;
  localparam logic [31:0] BEQ_M4     = 32'hFE00_0EE3;
  localparam logic [31:0] ILLEGAL    = 32'hFFFF_FFFF;

  decode dut (
    .clk(clk), .reset(reset), .ir(ir), .npc(npc), .branch_sig(branch_sig),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3), .ex_reg_we(ex_reg_we),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t ins(input logic [31:0] pc, rs1v, rs2v, input logic rs2c,
                               input logic [31:0] imm, input logic [4:0] rd,
                               input logic we, ld, br);
    exp_t e;
    e = '{valid: 1'b1, pc: pc, rs1_val: rs1v, rs2_val: rs2v, imm: imm, rd: rd,
          reg_we: we, is_load: ld, is_branch: br, illegal: 1'b0, data_chk: 1'b1, rs2_chk: rs2c};
    return e;
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '{valid: 1'b0, pc: '0, rs1_val: '0, rs2_val: '0, imm: '0, rd: '0,
          reg_we: 1'b0, is_load: 1'b0, is_branch: 1'b0, illegal: 1'b0, data_chk: 1'b1, rs2_chk: 1'b1};
    return e;
  endfunction

  task automatic step(input logic [31:0] ir_v, input logic [31:0] npc_v, input logic br,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic exp_stall, input exp_t e);
    exp_t g;
    @(negedge clk);
    ir = ir_v; npc = npc_v; branch_sig = br; wb_we = we; wb_rd = wrd; wb_data = wd;
    #1;
    check("stall", 32'(stall), 32'(exp_stall));
    sb.push_back(e);
    @(posedge clk);
    #1;
    wb_we = 1'b0; branch_sig = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      check("ex_valid", 32'(ex_valid), 32'(g.valid));
      check("ex_reg_we", 32'(ex_reg_we), 32'(g.reg_we));
      check("ex_is_load", 32'(ex_is_load), 32'(g.is_load));
      check("ex_is_branch", 32'(ex_is_branch), 32'(g.is_branch));
      check("ex_illegal", 32'(ex_illegal), 32'(g.illegal));
      if (g.data_chk) begin
        check("ex_pc", ex_pc, g.pc);
        check("ex_rs1_val", ex_rs1_val, g.rs1_val);
        check("ex_imm", ex_imm, g.imm);
        check("ex_rd", 32'(ex_rd), 32'(g.rd));
        if (g.rs2_chk) check("ex_rs2_val", ex_rs2_val, g.rs2_val);
      end
    end
    $display("txn ir=%h npc=%h br=%0d stall=%0d -> valid=%0d pc=%h rd=%0d rs1=%h rs2=%h imm=%h",
             ir_v, npc_v, br, exp_stall, ex_valid, ex_pc, ex_rd, ex_rs1_val, ex_rs2_val, ex_imm);
  endtask

  initial begin
    exp_t ill;
    ir = LW_X2_X1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_reg_we", 32'(ex_reg_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    step(ADDI_X1_5,  32'h8000, 0, 0, 5'd0, 32'h0,        0, ins(32'h8000, 0, 0, 1, 5, 1, 1, 0, 0));
    step(ADDI_X6_X5, 32'h8004, 0, 1, 5'd5, 32'hDEADBEEF, 0, ins(32'h8004, 32'hDEADBEEF, 0, 1, 0, 6, 1, 0, 0));
    step(ADDI_X6_X5, 32'h8004, 0, 0, 5'd0, 32'h0,        0, ins(32'h8004, 32'hDEADBEEF, 0, 1, 0, 6, 1, 0, 0));
    step(ADDI_X7_X0, 32'h8008, 0, 1, 5'd0, 32'h12345678, 0, ins(32'h8008, 0, 0, 1, 0, 7, 1, 0, 0));
    step(ADDI_X7_X0, 32'h8008, 0, 0, 5'd0, 32'h0,        0, ins(32'h8008, 0, 0, 1, 0, 7, 1, 0, 0));
    // Load-use: one stall cycle with a bubble, then the add re-reads x2 after writeback.
    step(LW_X2_X1,   32'h800C, 0, 1, 5'd1, 32'h100,      0, ins(32'h800C, 32'h100, 0, 1, 0, 2, 1, 1, 0));
    step(ADD_X3_X2,  32'h8010, 0, 1, 5'd2, 32'hCAFE,     1, bubble());
    step(ADD_X3_X2,  32'h8010, 0, 0, 5'd0, 32'h0,        0, ins(32'h8010, 32'hCAFE, 32'hCAFE, 1, 0, 3, 1, 0, 0));
    // Same hazard with a flush: no stall, bubble, and no stall afterwards.
    step(LW_X2_X1,   32'h8014, 0, 0, 5'd0, 32'h0,        0, ins(32'h8014, 32'h100, 0, 1, 0, 2, 1, 1, 0));
    step(ADD_X3_X2,  32'h8018, 1, 0, 5'd0, 32'h0,        0, bubble());
    step(ADD_X3_X2,  32'h801C, 0, 0, 5'd0, 32'h0,        0, ins(32'h801C, 32'hCAFE, 32'hCAFE, 1, 0, 3, 1, 0, 0));
    step(BEQ_M4,     32'h9000, 0, 0, 5'd0, 32'h0,        0, ins(32'h9000, 0, 0, 1, 32'hFFFFFFFC, 29, 0, 0, 1));
    ill = bubble();
    ill.valid = 1'b1; ill.illegal = 1'b1; ill.data_chk = 1'b0;
    step(ILLEGAL,    32'h9004, 0, 0, 5'd0, 32'h0,        0, ill);
    step(ADDI_X1_5,  32'hA000, 0, 0, 5'd0, 32'h0,        0, ins(32'hA000, 0, 0, 0, 5, 1, 1, 0, 0));

    // Asynchronous reset mid-cycle while ID/EX holds a valid instruction.
    @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(ex_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(ex_valid), 32'd0);
    check("async_rst_reg_we", 32'(ex_reg_we), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(ADDI_X6_X5, 32'hB000, 0, 0, 5'd0, 32'h0,        0, ins(32'hB000, 0, 0, 1, 0, 6, 1, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
